// File: rtl/vc_arbiter_pkg.sv
// Transaction-layer shared definitions for the VC arbiter: widths, FSM encodings,
// destination field position and the in-flight word descriptor.
package vc_arbiter_pkg;

    localparam int unsigned DATA_W   = 12;
    localparam int unsigned UMB_W    = 3;
    localparam int unsigned DEST_LSB = 8;
    localparam int unsigned N_DEST   = 4;

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_INIT   = 4'b0010;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    typedef struct packed {
        logic vld;
        logic vc;
    } inflight_t;

    // One-hot destination select from the word's destination field
    function automatic logic [N_DEST-1:0] dest_onehot(input logic [DATA_W-1:0] word);
        dest_onehot = N_DEST'(1) << word[DEST_LSB +: 2];
    endfunction

endpackage

// File: rtl/vc_rr_grant.sv
// VC pop grant: strict VC0 priority with a bounded-starvation escape for VC1.
module vc_rr_grant #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] vc_empty,
    output logic [1:0] vc_pop
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_vc0_rdy;
    logic             w_vc1_rdy;
    logic             w_force_vc1;

    assign w_vc0_rdy   = !vc_empty[0];
    assign w_vc1_rdy   = !vc_empty[1];
    assign w_force_vc1 = (r_starve_cnt == CNT_W'(STARVE_MAX)) && w_vc1_rdy;

    always_comb begin
        vc_pop = 2'b00;
        if (enable) begin
            if (w_vc0_rdy && !w_force_vc1) begin
                vc_pop = 2'b01;
            end else if (w_vc1_rdy) begin
                vc_pop = 2'b10;
            end
        end
    end

    // Counts VC0 wins that happen while VC1 is waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!w_vc1_rdy || vc_pop[1]) begin
            r_starve_cnt <= '0;
        end else if (vc_pop[0] && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vc_arbiter.sv
// VC arbiter top: control FSM, threshold latches, in-flight tracking and the
// destination demux that forwards each popped word to D0..D3.
module vc_arbiter
    import vc_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [UMB_W-1:0]  umbral_AF_in,
    input  logic [UMB_W-1:0]  umbral_AE_in,
    input  logic [1:0]        vc_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic [3:0]        d_almost_full,
    output logic [1:0]        vc_pop,
    output logic [3:0]        d_push,
    output logic [DATA_W-1:0] d_data,
    output logic [UMB_W-1:0]  umbral_AF_out,
    output logic [UMB_W-1:0]  umbral_AE_out,
    output logic [3:0]        state,
    output logic              idle
);

    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic              r_idle;
    logic [UMB_W-1:0]  r_umb_af;
    logic [UMB_W-1:0]  r_umb_ae;
    inflight_t         r_infl;
    logic              w_pop_en;
    logic [1:0]        w_vc_pop;
    logic [DATA_W-1:0] w_word;

    // No new pops while leaving ACTIVE or while any destination is nearly full
    assign w_pop_en = (r_state == ST_ACTIVE) && !init && !reset &&
                      (d_almost_full == 4'b0000);

    vc_rr_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk      (clk),
        .reset    (reset),
        .enable   (w_pop_en),
        .vc_empty (vc_empty),
        .vc_pop   (w_vc_pop)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET:  w_state_nxt = ST_INIT;
            ST_INIT:   if (!init) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (init)                     w_state_nxt = ST_INIT;
                else if (vc_empty != 2'b11)   w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                                     w_state_nxt = ST_INIT;
                else if ((vc_empty == 2'b11) && !r_infl.vld)  w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RESET;
            r_idle   <= 1'b0;
            r_umb_af <= '0;
            r_umb_ae <= '0;
            r_infl   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle     <= (w_state_nxt == ST_IDLE);
            r_infl.vld <= |w_vc_pop;
            r_infl.vc  <= w_vc_pop[1];
            if (r_state == ST_INIT) begin
                r_umb_af <= umbral_AF_in;
                r_umb_ae <= umbral_AE_in;
            end
        end
    end

    // FIFO read data is valid the cycle after the pop, so the demux is combinational
    assign w_word = r_infl.vc ? vc1_data : vc0_data;

    always_comb begin
        d_push = '0;
        d_data = '0;
        if (r_infl.vld && !reset) begin
            d_push = dest_onehot(w_word);
            d_data = w_word;
        end
    end

    assign vc_pop        = w_vc_pop;
    assign umbral_AF_out = r_umb_af;
    assign umbral_AE_out = r_umb_ae;
    assign state         = r_state;
    assign idle          = r_idle;

endmodule

// File: tb/tb_vc_arbiter.sv
// Self-checking bench for vc_arbiter: behavioural VC FIFOs, a cycle model of the
// arbitration rules and a scoreboard of expected destination pushes.
module tb_vc_arbiter;
    import vc_arbiter_pkg::*;

    localparam int STARVE = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              init = 1'b0;
    logic [UMB_W-1:0]  af_in = '0;
    logic [UMB_W-1:0]  ae_in = '0;
    logic [1:0]        vc_empty = 2'b11;
    logic [DATA_W-1:0] vc0_data = '0;
    logic [DATA_W-1:0] vc1_data = '0;
    logic [3:0]        d_af = '0;
    logic [1:0]        vc_pop;
    logic [3:0]        d_push;
    logic [DATA_W-1:0] d_data;
    logic [UMB_W-1:0]  af_out;
    logic [UMB_W-1:0]  ae_out;
    logic [3:0]        state;
    logic              idle;

    vc_arbiter #(.STARVE_MAX(STARVE)) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .umbral_AF_in  (af_in),
        .umbral_AE_in  (ae_in),
        .vc_empty      (vc_empty),
        .vc0_data      (vc0_data),
        .vc1_data      (vc1_data),
        .d_almost_full (d_af),
        .vc_pop        (vc_pop),
        .d_push        (d_push),
        .d_data        (d_data),
        .umbral_AF_out (af_out),
        .umbral_AE_out (ae_out),
        .state         (state),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [1:0]        pop_seen = 2'b00;
    bit                chk_en = 1'b0;

    logic [3:0]        m_state = 4'b0001;
    int                m_starve = 0;
    bit                m_pend = 1'b0;
    logic [UMB_W-1:0]  m_af = '0;
    logic [UMB_W-1:0]  m_ae = '0;

    int                grant_log[$];
    int                pop_cyc[$];
    logic [3:0]        dest_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic upd_empty();
        vc_empty = {q1.size() == 0, q0.size() == 0};
    endtask

    task automatic load(input int vc, input logic [DATA_W-1:0] w);
        if (vc == 0) q0.push_back(w);
        else         q1.push_back(w);
        upd_empty();
    endtask

    // Advance one clock; the FIFOs present popped data just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_seen[0] && q0.size() > 0) vc0_data = q0.pop_front();
        if (pop_seen[1] && q1.size() > 0) vc1_data = q1.pop_front();
        pop_seen = 2'b00;
        upd_empty();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 ||
                m_state != ST_IDLE) && n < 400) begin
            tick();
            n++;
        end
        check(name, 32'(n < 400), 32'd1);
    endtask

    // Reference model and scoreboard, evaluated mid-cycle when inputs are stable
    always @(negedge clk) begin
        logic [1:0]        e_pop;
        logic [3:0]        nx;
        logic [DATA_W-1:0] w;
        bit                e0, e1, pend_now;
        pop_seen = vc_pop;
        cyc++;
        if (chk_en) begin
            e0 = (q0.size() != 0);
            e1 = (q1.size() != 0);
            check("state", 32'(state), 32'(m_state));
            check("idle", 32'(idle), 32'(m_state == ST_IDLE));
            check("umbral_af", 32'(af_out), 32'(m_af));
            check("umbral_ae", 32'(ae_out), 32'(m_ae));

            e_pop = 2'b00;
            if (m_state == ST_ACTIVE && !init && !reset && d_af == 4'b0000) begin
                if (e0 && !(m_starve == STARVE && e1)) e_pop = 2'b01;
                else if (e1)                           e_pop = 2'b10;
            end
            check("vc_pop", 32'(vc_pop), 32'(e_pop));
            if (vc_pop != 2'b00) begin
                grant_log.push_back(vc_pop[1] ? 1 : 0);
                pop_cyc.push_back(cyc);
            end

            pend_now = m_pend;
            if (m_pend && !reset && exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("d_push", 32'(d_push), 32'(4'b0001 << w[DEST_LSB +: 2]));
                check("d_data", 32'(d_data), 32'(w));
                dest_log.push_back(d_push);
            end else begin
                check("d_push_quiet", 32'(d_push), 32'd0);
                check("d_data_quiet", 32'(d_data), 32'd0);
            end
            if (reset) exp_q.delete();

            m_pend = 1'b0;
            if (e_pop[0]) begin
                exp_q.push_back(q0[0]);
                m_pend = 1'b1;
            end else if (e_pop[1]) begin
                exp_q.push_back(q1[0]);
                m_pend = 1'b1;
            end

            if (reset || !e1 || e_pop[1]) m_starve = 0;
            else if (e_pop[0] && m_starve < STARVE) m_starve++;

            nx = m_state;
            if (reset) begin
                nx = ST_RESET;
                m_af = '0;
                m_ae = '0;
                m_pend = 1'b0;
            end else if (m_state == ST_RESET) begin
                nx = ST_INIT;
            end else if (m_state == ST_INIT) begin
                m_af = af_in;
                m_ae = ae_in;
                if (!init) nx = ST_IDLE;
            end else if (m_state == ST_IDLE) begin
                if (init)            nx = ST_INIT;
                else if (e0 || e1)   nx = ST_ACTIVE;
            end else begin
                if (init)                          nx = ST_INIT;
                else if (!e0 && !e1 && !pend_now)  nx = ST_IDLE;
            end
            m_state = nx;
        end
    end

    initial begin
        int exp_g[10];
        int n;
        logic [3:0] exp_d[4];
        exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        exp_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // T1: reset and INIT threshold latch
        tick();
        tick();
        chk_en = 1'b1;
        check("t1_reset_state", 32'(state), 32'h1);
        check("t1_reset_strobes", 32'({vc_pop, d_push}), 32'd0);
        reset = 1'b0;
        init  = 1'b1;
        af_in = 3'd6;
        ae_in = 3'd1;
        tick();
        tick();
        check("t1_init_state", 32'(state), 32'h2);
        check("t1_af_out", 32'(af_out), 32'd6);
        check("t1_ae_out", 32'(ae_out), 32'd1);
        init = 1'b0;
        tick();
        check("t1_idle_state", 32'(state), 32'h4);

        // T2: routing by destination field
        grant_log.delete(); pop_cyc.delete(); dest_log.delete();
        load(0, 12'h00A); load(0, 12'h10B); load(0, 12'h20C); load(0, 12'h30D);
        drain("t2_drain");
        check("t2_push_count", 32'(dest_log.size()), 32'd4);
        check("t2_pop_count", 32'(pop_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < dest_log.size(); i++)
            check("t2_dest", 32'(dest_log[i]), 32'(exp_d[i]));
        for (int i = 1; i < pop_cyc.size(); i++)
            check("t2_back_to_back", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
        check("t2_back_idle", 32'(state), 32'h4);

        // T3: priority with starvation escape
        grant_log.delete();
        for (int i = 0; i < 8; i++) load(0, DATA_W'($urandom));
        for (int i = 0; i < 2; i++) load(1, DATA_W'($urandom));
        drain("t3_drain");
        check("t3_grant_count", 32'(grant_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            check("t3_grant_seq", 32'(grant_log[i]), 32'(exp_g[i]));

        // T4: back-pressure mid-stream
        dest_log.delete();
        for (int i = 0; i < 8; i++) load(0, DATA_W'($urandom));
        tick(); tick(); tick();
        d_af = 4'b0100;
        #1;
        check("t4_pop_stopped", 32'(vc_pop), 32'd0);
        tick(); tick(); tick();
        d_af = 4'b0000;
        drain("t4_drain");
        check("t4_no_loss", 32'(dest_log.size()), 32'd8);

        // T5a: init during a burst
        dest_log.delete();
        for (int i = 0; i < 6; i++) load(0, DATA_W'($urandom));
        tick(); tick(); tick();
        init = 1'b1;
        tick();
        check("t5_init_state", 32'(state), 32'h2);
        init = 1'b0;
        drain("t5a_drain");
        check("t5a_no_loss", 32'(dest_log.size()), 32'd6);

        // T5b: reset during a burst drops the in-flight word
        for (int i = 0; i < 6; i++) load(1, DATA_W'($urandom));
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("t5b_state", 32'(state), 32'h1);
        check("t5b_outputs", 32'({vc_pop, d_push, d_data, af_out, ae_out, idle}), 32'd0);
        reset = 1'b0;
        drain("t5b_drain");

        // Randomised traffic with back-pressure and occasional init
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(2) == 0 && q0.size() < 12) load(0, DATA_W'($urandom));
            if ($urandom_range(3) == 0 && q1.size() < 12) load(1, DATA_W'($urandom));
            d_af = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0000;
            init = ($urandom_range(60) == 0);
            tick();
        end
        d_af = 4'b0000;
        init = 1'b0;
        drain("rand_drain");
        n = exp_q.size();
        check("scoreboard_empty", 32'(n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
